sha256_transform_core: RTL and testbench



---
 rtl/sha256_transform_core_pkg.sv | 54 +++++
 rtl/sha256_transform_core_if.sv | 11 +
 rtl/sha256_transform_core_round.sv | 36 +++
 rtl/sha256_transform_core.sv | 69 ++++++
 tb/tb_sha256_transform_core.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/sha256_transform_core_pkg.sv
// Shared SHA-256 constants and round primitives for the transform core and its round stages.
package sha256_pkg;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // H7 in the top word, H0 in the bottom word
    localparam logic [255:0] IV =
        256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) r[32*j +: 32] = x[32*j +: 32] + y[32*j +: 32];
        return r;
    endfunction

    function automatic bit loop_legal(input int l);
        return (l == 1) || (l == 2) || (l == 4) || (l == 8) || (l == 16) || (l == 32);
    endfunction

endpackage

// File: rtl/sha256_transform_core_if.sv
// Controller-to-core bundle: round schedule, block inputs and the captured digest.
interface sha256_transform_core_if;
    logic         feedback;
    logic [5:0]   cnt;
    logic [255:0] rx_state;
    logic [511:0] rx_input;
    logic [255:0] tx_hash;

    modport master (output feedback, cnt, rx_state, rx_input, input tx_hash);
    modport slave  (input feedback, cnt, rx_state, rx_input, output tx_hash);
endinterface

// File: rtl/sha256_transform_core_round.sv
// One registered SHA-256 round: updates the working state and slides the message window by a word.
module sha256_round
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic [31:0]  k,
    input  logic [255:0] rx_state,
    input  logic [511:0] rx_w,
    output logic [255:0] tx_state,
    output logic [511:0] tx_w
);

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2, w_next;

    always_comb begin
        {h, g, f, e, d, c, b, a} = rx_state;
        t1     = h + big_sigma1(e) + ch(e, f, g) + k + rx_w[31:0];
        t2     = big_sigma0(a) + maj(a, b, c);
        // schedule word 16 ahead of the one consumed this round
        w_next = small_sigma1(rx_w[14*32 +: 32]) + rx_w[9*32 +: 32]
               + small_sigma0(rx_w[1*32 +: 32]) + rx_w[31:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= '0;
            tx_w     <= '0;
        end else begin
            tx_state <= {g, f, e, d + t1, c, b, a, t1 + t2};
            tx_w     <= {w_next, rx_w[511:32]};
        end
    end

endmodule

// File: rtl/sha256_transform_core.sv
// SHA-256 compression engine: 64/LOOP round stages, each reused LOOP cycles under controller-driven cnt.
module sha256_transform_core
    import sha256_pkg::*;
#(
    parameter int LOOP = 1
)
(
    input  logic                   clk,
    input  logic                   reset_n,
    sha256_transform_core_if.slave bus
);

    localparam int S = 64 / LOOP;

    if (!loop_legal(LOOP)) begin : g_loop_check
        $error("sha256_transform_core: LOOP must be 1, 2, 4, 8, 16 or 32");
    end

    logic [255:0] state_p [S];
    logic [511:0] win_p   [S];
    logic [255:0] hash_q;

    for (genvar i = 0; i < S; i++) begin : g_stage
        localparam logic [5:0] K_BASE = 6'(LOOP * i);

        logic [255:0] prev_state, sel_state;
        logic [511:0] prev_win, sel_win;
        logic [5:0]   k_idx;
        logic [31:0]  k_val;

        if (i == 0) begin : g_head
            assign prev_state = bus.rx_state;
            assign prev_win   = bus.rx_input;
        end else begin : g_body
            assign prev_state = state_p[i-1];
            assign prev_win   = win_p[i-1];
        end

        // feedback keeps work parked in this stage; otherwise everything shifts one stage down
        always_comb begin
            k_idx     = K_BASE + bus.cnt;
            k_val     = K[k_idx];
            sel_state = bus.feedback ? state_p[i] : prev_state;
            sel_win   = bus.feedback ? win_p[i]   : prev_win;
        end

        sha256_round u_round (
            .clk      (clk),
            .reset_n  (reset_n),
            .k        (k_val),
            .rx_state (sel_state),
            .rx_w     (sel_win),
            .tx_state (state_p[i]),
            .tx_w     (win_p[i])
        );
    end

    // Output capture stage: the last stage has finished round 63 by every cnt=0 edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hash_q <= '0;
        end else if (!bus.feedback) begin
            hash_q <= add_words(bus.rx_state, state_p[S-1]);
        end
    end

    assign bus.tx_hash = hash_q;

endmodule

// File: tb/tb_sha256_transform_core.sv
// Bench for sha256_transform_core: one instance per legal LOOP, checked against a plain SHA-256 model.
module tb_sha256_transform_core;

    localparam int N = 6;

    localparam logic [31:0] KT [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV_C =
        256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;
    localparam logic [255:0] ABC_D =
        256'hf20015ad_b410ff61_96177a9c_b00361a3_5dae2223_414140de_8f01cfea_ba7816bf;
    localparam logic [255:0] EMPTY_D =
        256'h7852b855_a495991b_649b934c_27ae41e4_996fb924_9afbf4c8_98fc1c14_e3b0c442;

    typedef struct {
        int           g;
        logic [255:0] state;
        logic [511:0] blk;
        logic [255:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         fb    [N];
    logic [5:0]   cnt   [N];
    logic [255:0] st    [N];
    logic [511:0] blk_in[N];
    logic [255:0] tx    [N];

    int n_chk  = 0;
    int n_fail = 0;
    int nxt    = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        sha256_transform_core_if bus ();
        assign bus.feedback = fb[g];
        assign bus.cnt      = cnt[g];
        assign bus.rx_state = st[g];
        assign bus.rx_input = blk_in[g];
        assign tx[g]        = bus.tx_hash;

        sha256_transform_core #(.LOOP(1 << g)) dut (
            .clk     (clk),
            .reset_n (reset_n),
            .bus     (bus)
        );
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Straightforward FIPS 180-4 compression with a full 64-word schedule
    function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] m);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2, s0, s1;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = m[32*t +: 32];
        for (int t = 16; t < 64; t++) begin
            s0   = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1   = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        for (int j = 0; j < 8; j++) v[j] = h[32*j +: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        r = '0;
        for (int j = 0; j < 8; j++) r[32*j +: 32] = h[32*j +: 32] + v[j];
        return r;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input bit ok, input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one edge; the schedule for the following edge is set 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
        nxt++;
        for (int g = 0; g < N; g++) begin
            cnt[g] = 6'(nxt % (1 << g));
            fb[g]  = (cnt[g] != 6'd0);
        end
    endtask

    task automatic align();
        while (nxt % 32 != 0) tick();
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int t0;
        bit hold_ok;
        logic [255:0] bad;
        align();
        st[v.g]     = v.state;
        blk_in[v.g] = v.blk;
        t0 = nxt;
        while (nxt <= t0 + 64) tick();
        check(tx[v.g] === v.exp, name, tx[v.g], v.exp);
        hold_ok = 1'b1;
        bad     = v.exp;
        for (int j = 1; j < (1 << v.g); j++) begin
            tick();
            if (tx[v.g] !== v.exp) begin
                hold_ok = 1'b0;
                bad     = tx[v.g];
            end
        end
        check(hold_ok, {name, "_hold"}, bad, v.exp);
    endtask

    initial begin
        vec_t         vecs[$];
        vec_t         v;
        logic [511:0] abc_b, empty_b;
        logic [255:0] seq_exp [8];
        int           t0;

        abc_b          = '0;
        abc_b[31:0]    = 32'h61626380;
        abc_b[511:480] = 32'h00000018;
        empty_b        = '0;
        empty_b[31:0]  = 32'h80000000;

        for (int g = 0; g < N; g++) begin
            v.g = g; v.state = IV_C;  v.blk = abc_b;   v.exp = ABC_D;   vecs.push_back(v);
            v.g = g; v.state = IV_C;  v.blk = empty_b; v.exp = EMPTY_D; vecs.push_back(v);
            v.g = g; v.state = ABC_D; v.blk = empty_b; v.exp = compress(ABC_D, empty_b); vecs.push_back(v);
            for (int r = 0; r < 2; r++) begin
                v.g     = g;
                v.state = rnd256();
                v.blk   = {rnd256(), rnd256()};
                v.exp   = compress(v.state, v.blk);
                vecs.push_back(v);
            end
        end

        reset_n = 1'b0;
        for (int g = 0; g < N; g++) begin
            cnt[g] = '0; fb[g] = 1'b0; st[g] = IV_C; blk_in[g] = '0;
        end
        tick();
        tick();
        for (int g = 0; g < N; g++) check(tx[g] === '0, $sformatf("reset_l%0d", 1 << g), tx[g], '0);
        reset_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d_l%0d", i, 1 << vecs[i].g));

        // LOOP=1 fully pipelined: a new block every edge, alternating abc and empty
        align();
        st[0] = IV_C;
        t0    = nxt;
        for (int j = 0; j < 8; j++) begin
            blk_in[0]  = (j % 2 == 0) ? abc_b : empty_b;
            seq_exp[j] = (j % 2 == 0) ? ABC_D : EMPTY_D;
            tick();
        end
        while (nxt < t0 + 65) tick();
        for (int j = 0; j < 8; j++) begin
            check(tx[0] === seq_exp[j], $sformatf("b2b%0d", j), tx[0], seq_exp[j]);
            tick();
        end

        // Reset in the middle of a LOOP=8 hash, then a clean restart
        align();
        st[3]     = IV_C;
        blk_in[3] = abc_b;
        repeat (20) tick();
        reset_n = 1'b0;
        #1;
        check(tx[3] === '0, "midreset_now", tx[3], '0);
        tick();
        tick();
        check(tx[3] === '0, "midreset_held", tx[3], '0);
        reset_n = 1'b1;
        v.g = 3; v.state = IV_C; v.blk = abc_b; v.exp = ABC_D;
        run_vec(v, "after_reset_l8");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
